// File: rtl/stripes_mac_ctrl_if.sv
// Weight-tile handshake bundle between a tile producer and stripes_mac_ctrl.
//   w_valid  : producer offers a tile
//   w_ready  : controller can accept (shadow buffer empty)
//   w_in     : lane-indexed signed weights, DATA_WIDTH bits per lane
//   w_prec   : requested precision P (0 or > DATA_WIDTH means DATA_WIDTH)
//   cfg_pool : tile is a pooling tile
interface stripes_mac_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned VEC_LENGTH = 16,
  parameter int unsigned PREC_WIDTH = 4
);
  logic                                  w_valid;
  logic                                  w_ready;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_in;
  logic [PREC_WIDTH-1:0]                 w_prec;
  logic                                  cfg_pool;

  modport master (output w_valid, w_in, w_prec, cfg_pool, input w_ready);
  modport slave  (input w_valid, w_in, w_prec, cfg_pool, output w_ready);
endinterface

// File: rtl/stripes_mac_ctrl.sv
// Bit-serial sequencer for the Stripes MAC: double-buffers weight tiles and
// streams one weight bit per lane per cycle, MSB first, with MAC controls.
//   clk, reset       : clock, synchronous active-high reset
//   w_if             : tile handshake (slave side)
//   w_bit_o          : current weight bit per lane (0 outside RUN)
//   is_msb_o         : current bit is the sign bit
//   delayed_is_msb_o : is_msb_o delayed one cycle
//   mac_en_o         : MAC enable (RUN and DRAIN)
//   is_pooling_o     : pool flag of the tile whose result is accumulating
//   result_valid_o   : MAC result holds a finished dot product
//   busy_o           : any tile in flight or result pending
module stripes_mac_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned VEC_LENGTH = 16,
  parameter int unsigned PREC_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  stripes_mac_ctrl_if.slave     w_if,
  output logic [VEC_LENGTH-1:0] w_bit_o,
  output logic                  is_msb_o,
  output logic                  delayed_is_msb_o,
  output logic                  mac_en_o,
  output logic                  is_pooling_o,
  output logic                  result_valid_o,
  output logic                  busy_o
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned P_W   = $clog2(DATA_WIDTH + 1);

  typedef logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e            state_q, state_d;
  vec_t              act_w_q, act_w_d, sh_w_q, sh_w_d;
  logic [P_W-1:0]    act_p_q, act_p_d, sh_p_q, sh_p_d;
  logic              act_pool_q, act_pool_d, sh_pool_q, sh_pool_d;
  logic              sh_full_q, sh_full_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              last_q, last_d;
  logic              pool_msb_q, pool_msb_d;
  logic [VEC_LENGTH-1:0] w_bit_q, w_bit_d;
  logic              is_msb_q, is_msb_d, dmsb_q, dmsb_d, mac_en_q, mac_en_d;
  logic              is_pooling_q, is_pooling_d, rv_q, rv_d, busy_q, busy_d;
  logic              w_ready_q, w_ready_d;

  logic [P_W-1:0]    in_p_c, src_p_c;
  logic              hs_c, last_bit_c, load_c;

  // Clamp requested precision: 0 or anything above DATA_WIDTH means full width.
  always_comb begin
    in_p_c = P_W'(w_if.w_prec);
    if (w_if.w_prec == '0 || 32'(w_if.w_prec) > DATA_WIDTH) begin
      in_p_c = P_W'(DATA_WIDTH);
    end
  end

  // Next-state, buffer movement and next-cycle output values.
  always_comb begin
    state_d      = state_q;
    act_w_d      = act_w_q;
    act_p_d      = act_p_q;
    act_pool_d   = act_pool_q;
    sh_w_d       = sh_w_q;
    sh_p_d       = sh_p_q;
    sh_pool_d    = sh_pool_q;
    sh_full_d    = sh_full_q;
    idx_d        = idx_q;
    w_bit_d      = '0;

    hs_c       = w_if.w_valid && w_ready_q;
    last_bit_c = (state_q == S_RUN) && (idx_q == '0);
    // Active register may be (re)loaded when idle, draining, or on the last bit.
    load_c     = ((state_q == S_IDLE) || (state_q == S_DRAIN) || last_bit_c) &&
                 (sh_full_q || hs_c);
    src_p_c    = sh_full_q ? sh_p_q : in_p_c;

    unique case (state_q)
      S_IDLE:  if (load_c) state_d = S_RUN;
      S_RUN: begin
        if (idx_q != '0) idx_d = idx_q - IDX_W'(1);
        else             state_d = load_c ? S_RUN : S_DRAIN;
      end
      S_DRAIN: state_d = load_c ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load_c) begin
      idx_d = IDX_W'(src_p_c - P_W'(1));
      if (sh_full_q) begin
        act_w_d    = sh_w_q;
        act_p_d    = sh_p_q;
        act_pool_d = sh_pool_q;
        sh_full_d  = 1'b0;
      end else begin
        // Same-cycle handshake bypasses the empty shadow.
        act_w_d    = w_if.w_in;
        act_p_d    = in_p_c;
        act_pool_d = w_if.cfg_pool;
      end
    end else if (hs_c) begin
      sh_w_d    = w_if.w_in;
      sh_p_d    = in_p_c;
      sh_pool_d = w_if.cfg_pool;
      sh_full_d = 1'b1;
    end

    for (int unsigned j = 0; j < VEC_LENGTH; j++) begin
      w_bit_d[j] = (state_d == S_RUN) ? act_w_d[j][idx_d] : 1'b0;
    end
    is_msb_d     = (state_d == S_RUN) && (P_W'(idx_d) == act_p_d - P_W'(1));
    mac_en_d     = (state_d != S_IDLE);
    dmsb_d       = is_msb_q;
    // Pool flag travels with the MSB so a back-to-back tile cannot overwrite it
    // before the previous tile's result_valid.
    pool_msb_d   = is_msb_q ? act_pool_q : pool_msb_q;
    is_pooling_d = dmsb_q ? pool_msb_q : is_pooling_q;
    last_d       = last_bit_c;
    rv_d         = last_q;
    w_ready_d    = !sh_full_d;
    busy_d       = (state_d != S_IDLE) || sh_full_d || last_d || rv_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      act_w_q      <= '0;
      act_p_q      <= '0;
      act_pool_q   <= 1'b0;
      sh_w_q       <= '0;
      sh_p_q       <= '0;
      sh_pool_q    <= 1'b0;
      sh_full_q    <= 1'b0;
      idx_q        <= '0;
      last_q       <= 1'b0;
      pool_msb_q   <= 1'b0;
      w_bit_q      <= '0;
      is_msb_q     <= 1'b0;
      dmsb_q       <= 1'b0;
      mac_en_q     <= 1'b0;
      is_pooling_q <= 1'b0;
      rv_q         <= 1'b0;
      busy_q       <= 1'b0;
      w_ready_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      act_w_q      <= act_w_d;
      act_p_q      <= act_p_d;
      act_pool_q   <= act_pool_d;
      sh_w_q       <= sh_w_d;
      sh_p_q       <= sh_p_d;
      sh_pool_q    <= sh_pool_d;
      sh_full_q    <= sh_full_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      pool_msb_q   <= pool_msb_d;
      w_bit_q      <= w_bit_d;
      is_msb_q     <= is_msb_d;
      dmsb_q       <= dmsb_d;
      mac_en_q     <= mac_en_d;
      is_pooling_q <= is_pooling_d;
      rv_q         <= rv_d;
      busy_q       <= busy_d;
      w_ready_q    <= w_ready_d;
    end
  end

  assign w_if.w_ready     = w_ready_q;
  assign w_bit_o          = w_bit_q;
  assign is_msb_o         = is_msb_q;
  assign delayed_is_msb_o = dmsb_q;
  assign mac_en_o         = mac_en_q;
  assign is_pooling_o     = is_pooling_q;
  assign result_valid_o   = rv_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_stripes_mac_ctrl.sv
// Self-checking bench for stripes_mac_ctrl: a tile-schedule model predicts
// every output from accept times and precisions.
module tb_stripes_mac_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned VL = 16;
  localparam int unsigned PW = 4;

  typedef logic [VL-1:0][DW-1:0] vec_t;
  typedef struct {
    int   acc;
    int   st;
    int   lst;
    int   p;
    logic pool;
    vec_t w;
  } tile_t;
  typedef struct packed {
    logic          ready;
    logic          busy;
    logic          mac;
    logic          msb;
    logic          dmsb;
    logic          rv;
    logic [VL-1:0] wbit;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  logic [VL-1:0] w_bit_o;
  logic is_msb_o, delayed_is_msb_o, mac_en_o, is_pooling_o, result_valid_o, busy_o;

  stripes_mac_ctrl_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .PREC_WIDTH(PW)) wif ();

  stripes_mac_ctrl #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .PREC_WIDTH(PW)) dut (
    .clk              (clk),
    .reset            (reset),
    .w_if             (wif.slave),
    .w_bit_o          (w_bit_o),
    .is_msb_o         (is_msb_o),
    .delayed_is_msb_o (delayed_is_msb_o),
    .mac_en_o         (mac_en_o),
    .is_pooling_o     (is_pooling_o),
    .result_valid_o   (result_valid_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  tile_t tiles[$];
  int    cyc;
  int    errors;
  int    checks;
  obs_t  exp_o, got_o;
  vec_t  zero_w;

  function automatic int eff_p(int prec);
    return (prec == 0 || prec > int'(DW)) ? int'(DW) : prec;
  endfunction

  // A tile waits in the shadow from the cycle after its accept until its start.
  function automatic logic model_ready(int c);
    foreach (tiles[i]) if (tiles[i].acc + 1 <= c && c <= tiles[i].st - 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic obs_t model_out(int c);
    obs_t o;
    logic starts;
    o = '0;
    o.ready = model_ready(c);
    starts = 1'b0;
    foreach (tiles[i]) if (tiles[i].st == c) starts = 1'b1;
    foreach (tiles[i]) begin
      if (tiles[i].st <= c && c <= tiles[i].lst) begin
        int b;
        b = tiles[i].p - 1 - (c - tiles[i].st);
        for (int j = 0; j < int'(VL); j++) o.wbit[j] = tiles[i].w[j][b];
        o.mac = 1'b1;
      end
      if (c == tiles[i].lst + 1 && !starts) o.mac = 1'b1;
      if (c == tiles[i].st) o.msb = 1'b1;
      if (c == tiles[i].st + 1) o.dmsb = 1'b1;
      if (c == tiles[i].lst + 2) o.rv = 1'b1;
      if (tiles[i].acc + 1 <= c && c <= tiles[i].lst + 2) o.busy = 1'b1;
    end
    return o;
  endfunction

  function automatic logic model_pool(int c);
    foreach (tiles[i]) if (c == tiles[i].lst + 2) return tiles[i].pool;
    return 1'b0;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ready = wif.w_ready;
    o.busy  = busy_o;
    o.mac   = mac_en_o;
    o.msb   = is_msb_o;
    o.dmsb  = delayed_is_msb_o;
    o.rv    = result_valid_o;
    o.wbit  = w_bit_o;
    return o;
  endfunction

  function automatic vec_t rand_w();
    vec_t w;
    for (int j = 0; j < int'(VL); j++) w[j] = DW'($urandom);
    return w;
  endfunction

  function automatic vec_t fill_w(logic [DW-1:0] v);
    vec_t w;
    for (int j = 0; j < int'(VL); j++) w[j] = v;
    return w;
  endfunction

  // Drive one cycle (called at the negedge) and advance to the next negedge.
  task automatic tick(input logic v, input vec_t w, input int prec, input logic pool,
                      input logic rst);
    wif.w_valid  = v;
    wif.w_in     = w;
    wif.w_prec   = PW'(prec);
    wif.cfg_pool = pool;
    reset        = rst;
    if (!rst && v && model_ready(cyc)) begin
      tile_t t;
      t.acc  = cyc;
      t.p    = eff_p(prec);
      t.st   = cyc + 1;
      if (tiles.size() > 0 && tiles[tiles.size()-1].lst + 1 > t.st)
        t.st = tiles[tiles.size()-1].lst + 1;
      t.lst  = t.st + t.p - 1;
      t.pool = pool;
      t.w    = w;
      tiles.push_back(t);
    end
    @(posedge clk);
    cyc++;
    if (rst) tiles.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, zero_w, 0, 1'b0, 1'b1);
    got_o = sample();
    checks++;
    if (got_o !== obs_t'({1'b1, 5'b0, 16'h0})) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", got_o, obs_t'({1'b1, 5'b0, 16'h0}));
    end
    checks++;
    if (is_pooling_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_pool got=%b exp=0", is_pooling_o);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, zero_w, 0, 1'b0, 1'b0);
      exp_o = model_out(cyc); got_o = sample(); checks++;
      if (got_o !== exp_o) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, got_o, exp_o);
      end
    end
  endtask

  task automatic test_single();
    int t0, rv_at, rv_n;
    t0 = cyc; rv_at = -1; rv_n = 0;
    tick(1'b1, fill_w(8'h81), 8, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      exp_o = model_out(cyc); got_o = sample(); checks++;
      if (got_o !== exp_o) begin
        errors++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, got_o, exp_o);
      end
      if (result_valid_o === 1'b1) begin rv_at = cyc; rv_n++; end
      tick(1'b0, zero_w, 0, 1'b0, 1'b0);
    end
    checks++;
    if (rv_at !== t0 + 10 || rv_n !== 1) begin
      errors++; $display("FAIL single_rv_time got=%0d(n=%0d) exp=%0d", rv_at - t0, rv_n, 10);
    end
  endtask

  task automatic test_back_to_back();
    int t0, k;
    int msb_at[$];
    t0 = cyc; k = 0;
    for (int i = 0; i < 20; i++) begin
      logic v, acc;
      v = (k < 3);
      acc = v && model_ready(cyc);
      tick(v, rand_w(), 4, 1'b0, 1'b0);
      if (acc) k++;
      exp_o = model_out(cyc); got_o = sample(); checks++;
      if (got_o !== exp_o) begin
        errors++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, got_o, exp_o);
      end
      if (is_msb_o === 1'b1) msb_at.push_back(cyc - t0);
    end
    checks++;
    if (msb_at.size() != 3 || msb_at[0] != 1 || msb_at[1] != 5 || msb_at[2] != 9) begin
      errors++; $display("FAIL b2b_msb_times got_n=%0d exp=1,5,9", msb_at.size());
    end
  endtask

  task automatic test_prec();
    int precs[5] = '{0, 9, 15, 3, 1};
    foreach (precs[n]) begin
      int t0, rv_at;
      vec_t w;
      t0 = cyc; rv_at = -1;
      w = (precs[n] == 3) ? fill_w(8'h05) : rand_w();
      tick(1'b1, w, precs[n], 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) begin
        exp_o = model_out(cyc); got_o = sample(); checks++;
        if (got_o !== exp_o) begin
          errors++; $display("FAIL prec%0d cyc=%0d got=%h exp=%h", precs[n], cyc, got_o, exp_o);
        end
        if (result_valid_o === 1'b1) rv_at = cyc;
        tick(1'b0, zero_w, 0, 1'b0, 1'b0);
      end
      checks++;
      if (rv_at !== t0 + eff_p(precs[n]) + 2) begin
        errors++;
        $display("FAIL prec%0d_rv_time got=%0d exp=%0d", precs[n], rv_at - t0, eff_p(precs[n]) + 2);
      end
    end
  endtask

  task automatic test_pooling();
    int k;
    logic pools[$];
    k = 0;
    for (int i = 0; i < 16; i++) begin
      logic v, acc;
      v = (k < 2);
      acc = v && model_ready(cyc);
      tick(v, rand_w(), 4, (k == 0), 1'b0);
      if (acc) k++;
      exp_o = model_out(cyc); got_o = sample(); checks++;
      if (got_o !== exp_o) begin
        errors++; $display("FAIL pooling cyc=%0d got=%h exp=%h", cyc, got_o, exp_o);
      end
      if (exp_o.rv) begin
        checks++;
        if (is_pooling_o !== model_pool(cyc)) begin
          errors++; $display("FAIL pooling_flag cyc=%0d got=%b exp=%b", cyc, is_pooling_o, model_pool(cyc));
        end
      end
      if (result_valid_o === 1'b1) pools.push_back(is_pooling_o);
    end
    checks++;
    if (pools.size() != 2 || pools[0] !== 1'b1 || pools[1] !== 1'b0) begin
      errors++; $display("FAIL pooling_sequence got_n=%0d exp=1,0", pools.size());
    end
  endtask

  task automatic test_reset_midrun();
    int rv_n;
    rv_n = 0;
    tick(1'b1, rand_w(), 8, 1'b1, 1'b0);
    tick(1'b1, rand_w(), 8, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_o = model_out(cyc); got_o = sample(); checks++;
      if (got_o !== exp_o) begin
        errors++; $display("FAIL midrun_pre cyc=%0d got=%h exp=%h", cyc, got_o, exp_o);
      end
      tick(1'b0, zero_w, 0, 1'b0, 1'b0);
    end
    tick(1'b0, zero_w, 0, 1'b0, 1'b1);
    got_o = sample(); checks++;
    if (got_o !== obs_t'({1'b1, 5'b0, 16'h0}) || is_pooling_o !== 1'b0) begin
      errors++; $display("FAIL midrun_reset got=%h pool=%b exp=%h pool=0", got_o, is_pooling_o,
                         obs_t'({1'b1, 5'b0, 16'h0}));
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, zero_w, 0, 1'b0, 1'b0);
      if (result_valid_o === 1'b1) rv_n++;
    end
    checks++;
    if (rv_n !== 0) begin
      errors++; $display("FAIL midrun_no_rv got=%0d exp=0", rv_n);
    end
    tick(1'b1, rand_w(), 5, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      exp_o = model_out(cyc); got_o = sample(); checks++;
      if (got_o !== exp_o) begin
        errors++; $display("FAIL midrun_restart cyc=%0d got=%h exp=%h", cyc, got_o, exp_o);
      end
      tick(1'b0, zero_w, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 420; i++) begin
      logic v;
      v = (i < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick(v, rand_w(), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      exp_o = model_out(cyc); got_o = sample(); checks++;
      if (got_o !== exp_o) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got_o, exp_o);
      end
      if (exp_o.rv) begin
        checks++;
        if (is_pooling_o !== model_pool(cyc)) begin
          errors++; $display("FAIL random_pool cyc=%0d got=%b exp=%b", cyc, is_pooling_o, model_pool(cyc));
        end
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; zero_w = '0;
    reset = 1'b1;
    wif.w_valid = 1'b0; wif.w_in = '0; wif.w_prec = '0; wif.cfg_pool = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_prec();
    test_pooling();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
